free_list: RTL and testbench

- Circular-buffer physical-register free list for the R10K-style rename stage.
- Supplies up to DP_NUM free physical tags per cycle to dispatch. Dispatch writes these tags into the map table as the new mapping for rd.
- Reclaims the tag_old of retiring instructions.
- On rollback, restores itself in one cycle to the retire-time state, consistent with the map table reloading from the AMT.

---
 rtl/free_list.sv | 134 +++++++++++++
 tb/tb_free_list.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
`default_nettype none
// ============================================================================
// Module   : free_list
// Purpose  : Circular-buffer physical-register free list for R10K-style rename.
// Revision : 1.0 - initial release
// ============================================================================
module free_list #(
  parameter int DP_NUM   = 2,
  parameter int RT_NUM   = 2,
  parameter int AREG_NUM = 32,
  parameter int PREG_NUM = 64
) (
  input  logic                                                 clk_i,
  input  logic                                                 rst_i,
  input  logic                                                 rollback_i,
  input  logic [DP_NUM-1:0]                                    dp_alloc_i,
  output logic [DP_NUM*$clog2(PREG_NUM)-1:0]                   fl_dp_tag_o,
  output logic [$clog2(DP_NUM+1)-1:0]                          fl_avail_num_o,
  input  logic [RT_NUM-1:0]                                    rt_free_i,
  input  logic [RT_NUM*$clog2(PREG_NUM)-1:0]                   rt_tag_i,
  output logic [$clog2(PREG_NUM-AREG_NUM):0]                   fl_cnt_o
);

  localparam int c_FL_ENTRY = PREG_NUM - AREG_NUM;
  localparam int c_IDX_W    = $clog2(c_FL_ENTRY);
  localparam int c_PTR_W    = c_IDX_W + 1;
  localparam int c_TAG_W    = $clog2(PREG_NUM);
  localparam int c_AV_W     = $clog2(DP_NUM + 1);

  logic [c_TAG_W-1:0] r_entry [c_FL_ENTRY];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_PTR_W-1:0] r_rt_head;

  logic [c_PTR_W-1:0] w_count;
  logic [c_AV_W-1:0]  w_avail;
  logic [c_PTR_W-1:0] w_n_req;
  logic [c_PTR_W-1:0] w_n_grant;
  logic [c_PTR_W-1:0] w_n_free;
  logic [c_IDX_W-1:0] w_free_idx [RT_NUM];

  // Wrap bit makes tail - head distinguish full (FL_ENTRY) from empty (0).
  assign w_count  = r_tail - r_head;
  assign fl_cnt_o = w_count;

  always_comb begin
    w_avail = AV_W_CAST(DP_NUM);
    if (w_count < c_PTR_W'(DP_NUM)) begin
      w_avail = c_AV_W'(w_count);
    end
  end
  assign fl_avail_num_o = w_avail;

  function automatic logic [c_AV_W-1:0] AV_W_CAST(input int v);
    return c_AV_W'(v);
  endfunction

  always_comb begin
    w_n_req   = '0;
    w_n_grant = '0;
    for (int k = 0; k < DP_NUM; k++) begin
      if (dp_alloc_i[k]) begin
        w_n_req = w_n_req + c_PTR_W'(1);
        if (k < int'(w_avail) && !rollback_i) begin
          w_n_grant = w_n_grant + c_PTR_W'(1);
        end
      end
    end
  end

  // Valid retire slots are packed in slot order starting at tail.
  always_comb begin
    logic [c_IDX_W-1:0] v_off;
    v_off    = '0;
    w_n_free = '0;
    for (int s = 0; s < RT_NUM; s++) begin
      w_free_idx[s] = r_tail[c_IDX_W-1:0] + v_off;
      if (rt_free_i[s]) begin
        v_off    = v_off + c_IDX_W'(1);
        w_n_free = w_n_free + c_PTR_W'(1);
      end
    end
  end

  generate
    for (genvar k = 0; k < DP_NUM; k++) begin : g_tag
      logic [c_IDX_W-1:0] w_rd_idx;
      assign w_rd_idx = r_head[c_IDX_W-1:0] + c_IDX_W'(k);
      assign fl_dp_tag_o[k*c_TAG_W +: c_TAG_W] = r_entry[w_rd_idx];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < c_FL_ENTRY; i++) begin
        r_entry[i] <= c_TAG_W'(AREG_NUM + i);
      end
      r_head    <= '0;
      r_rt_head <= '0;
      r_tail    <= c_PTR_W'(c_FL_ENTRY);
    end else begin
      for (int s = 0; s < RT_NUM; s++) begin
        if (rt_free_i[s]) begin
          r_entry[w_free_idx[s]] <= rt_tag_i[s*c_TAG_W +: c_TAG_W];
        end
      end
      r_tail    <= r_tail + w_n_free;
      r_rt_head <= r_rt_head + w_n_free;
      // Rollback lands head on the retire-time pointer, including this cycle's frees.
      if (rollback_i) begin
        r_head <= r_rt_head + w_n_free;
      end else begin
        r_head <= r_head + w_n_grant;
      end
    end
  end

  always @(posedge clk_i) begin
    if (rst_i) begin
      assert (rollback_i || (w_n_req <= c_PTR_W'(w_avail)))
        else $error("free_list: allocate request exceeds available tags");
      assert ((dp_alloc_i & (dp_alloc_i + DP_NUM'(1))) == '0)
        else $error("free_list: allocate request not contiguous from slot 0");
      assert (rollback_i || (int'(w_count) + int'(w_n_free) <= c_FL_ENTRY))
        else $error("free_list: push beyond capacity");
      for (int s = 0; s < RT_NUM; s++) begin
        assert (!rt_free_i[s] || (rt_tag_i[s*c_TAG_W +: c_TAG_W] != '0))
          else $error("free_list: tag 0 freed");
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_free_list.sv
`default_nettype none
// ============================================================================
// Module   : tb_free_list
// Purpose  : Directed and randomized checks of free_list against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_free_list;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        rollback_i = 1'b0;
  logic [1:0]  dp_alloc_i = '0;
  logic [11:0] fl_dp_tag_o;
  logic [1:0]  fl_avail_num_o;
  logic [1:0]  rt_free_i = '0;
  logic [11:0] rt_tag_i = '0;
  logic [5:0]  fl_cnt_o;

  int checks   = 0;
  int failures = 0;

  // Model: fl holds free tags in offer order; spec holds allocated-but-not-retired tags.
  int fl[$];
  int spec[$];

  free_list #(.DP_NUM(2), .RT_NUM(2), .AREG_NUM(32), .PREG_NUM(64)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .rollback_i     (rollback_i),
    .dp_alloc_i     (dp_alloc_i),
    .fl_dp_tag_o    (fl_dp_tag_o),
    .fl_avail_num_o (fl_avail_num_o),
    .rt_free_i      (rt_free_i),
    .rt_tag_i       (rt_tag_i),
    .fl_cnt_o       (fl_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0d exp=%0d", name, obs, exp);
    end
  endtask

  function automatic int popc2(input logic [1:0] m);
    return int'(m[0]) + int'(m[1]);
  endfunction

  function automatic int min2(input int a);
    return (a < 2) ? a : 2;
  endfunction

  task automatic model_reset();
    fl.delete();
    spec.delete();
    for (int i = 0; i < 32; i++) fl.push_back(32 + i);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_cnt"}, 32'(fl_cnt_o), 32'(fl.size()));
    chk({tag, "_avail"}, 32'(fl_avail_num_o), 32'(min2(fl.size())));
    if (fl.size() > 0) chk({tag, "_tag0"}, 32'(fl_dp_tag_o[5:0]), 32'(fl[0]));
    if (fl.size() > 1) chk({tag, "_tag1"}, 32'(fl_dp_tag_o[11:6]), 32'(fl[1]));
  endtask

  task automatic do_reset(input logic [1:0] alloc);
    rst_i      = 1'b0;
    dp_alloc_i = alloc;
    rt_free_i  = 2'b11;
    rt_tag_i   = {6'd21, 6'd20};
    rollback_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i      = 1'b1;
    dp_alloc_i = '0;
    rt_free_i  = '0;
    rollback_i = 1'b0;
    model_reset();
    check_model("reset");
  endtask

  task automatic cycle(input string tag, input logic [1:0] alloc, input logic [1:0] fr,
                       input int t0, input int t1, input logic rb);
    int pre_avail, g;
    dp_alloc_i = alloc;
    rt_free_i  = fr;
    rt_tag_i   = {6'(t1), 6'(t0)};
    rollback_i = rb;
    pre_avail  = min2(fl.size());
    @(posedge clk_i); #1;
    for (int s = 0; s < 2; s++) begin
      if (fr[s]) begin
        // Each freeing retiree consumed the oldest outstanding allocation.
        if (spec.size() > 0) void'(spec.pop_front());
        else if (rb && fl.size() > 0) void'(fl.pop_front());
        fl.push_back((s == 0) ? t0 : t1);
      end
    end
    if (rb) begin
      fl = {spec, fl};
      spec.delete();
    end else begin
      g = popc2(alloc);
      if (g > pre_avail) g = pre_avail;
      for (int k = 0; k < g; k++) spec.push_back(fl.pop_front());
    end
    dp_alloc_i = '0;
    rt_free_i  = '0;
    rollback_i = 1'b0;
    check_model(tag);
  endtask

  initial begin
    logic [1:0] am, fm;
    int n, pa;

    // Reset values, then reset mid-run with requests pending.
    #1;
    do_reset(2'b00);
    chk("t1_tag0", 32'(fl_dp_tag_o[5:0]), 32'd32);
    chk("t1_tag1", 32'(fl_dp_tag_o[11:6]), 32'd33);
    cycle("t1_a", 2'b11, 2'b00, 0, 0, 1'b0);
    cycle("t1_b", 2'b01, 2'b00, 0, 0, 1'b0);
    do_reset(2'b11);
    chk("t1_mid_cnt", 32'(fl_cnt_o), 32'd32);
    chk("t1_mid_tag0", 32'(fl_dp_tag_o[5:0]), 32'd32);

    // Drain the list two at a time.
    for (int i = 0; i < 16; i++) begin
      chk("t2_tag0", 32'(fl_dp_tag_o[5:0]), 32'(32 + 2 * i));
      chk("t2_tag1", 32'(fl_dp_tag_o[11:6]), 32'(33 + 2 * i));
      cycle("t2", 2'b11, 2'b00, 0, 0, 1'b0);
    end
    chk("t2_cnt", 32'(fl_cnt_o), 32'd0);
    chk("t2_avail", 32'(fl_avail_num_o), 32'd0);

    // Free into an empty list: no bypass, visible next cycle.
    rt_free_i = 2'b11;
    rt_tag_i  = {6'd7, 6'd5};
    #2;
    chk("t3_same_avail", 32'(fl_avail_num_o), 32'd0);
    cycle("t3", 2'b00, 2'b11, 5, 7, 1'b0);
    chk("t3_avail", 32'(fl_avail_num_o), 32'd2);
    chk("t3_tag0", 32'(fl_dp_tag_o[5:0]), 32'd5);
    chk("t3_tag1", 32'(fl_dp_tag_o[11:6]), 32'd7);

    // Allocate 4, retire one, roll back.
    do_reset(2'b00);
    cycle("t4_a", 2'b11, 2'b00, 0, 0, 1'b0);
    cycle("t4_b", 2'b11, 2'b00, 0, 0, 1'b0);
    cycle("t4_c", 2'b00, 2'b01, 3, 0, 1'b0);
    cycle("t4_rb", 2'b00, 2'b00, 0, 0, 1'b1);
    chk("t4_cnt", 32'(fl_cnt_o), 32'd32);
    chk("t4_tag0", 32'(fl_dp_tag_o[5:0]), 32'd33);
    chk("t4_tag1", 32'(fl_dp_tag_o[11:6]), 32'd34);

    // Allocate, free and rollback together from reset.
    do_reset(2'b00);
    cycle("t5", 2'b01, 2'b01, 9, 0, 1'b1);
    chk("t5_cnt", 32'(fl_cnt_o), 32'd32);
    chk("t5_tag0", 32'(fl_dp_tag_o[5:0]), 32'd33);

    // Single grant alongside a free at count=1.
    do_reset(2'b00);
    for (int i = 0; i < 15; i++) cycle("t6_fill", 2'b11, 2'b00, 0, 0, 1'b0);
    cycle("t6_one", 2'b01, 2'b00, 0, 0, 1'b0);
    chk("t6_pre_cnt", 32'(fl_cnt_o), 32'd1);
    chk("t6_pre_tag0", 32'(fl_dp_tag_o[5:0]), 32'd63);
    cycle("t6", 2'b01, 2'b01, 12, 0, 1'b0);
    chk("t6_cnt", 32'(fl_cnt_o), 32'd1);
    chk("t6_tag0", 32'(fl_dp_tag_o[5:0]), 32'd12);

    // Randomized traffic within the legal envelope.
    do_reset(2'b00);
    for (int i = 0; i < 400; i++) begin
      pa = min2(fl.size());
      n  = $urandom_range(0, pa);
      am = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
      fm = 2'($urandom_range(0, 3));
      if (popc2(fm) > spec.size()) begin
        if (spec.size() == 0) fm = 2'b00;
        else fm = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      end
      cycle("rand", am, fm, $urandom_range(1, 63), $urandom_range(1, 63),
            ($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
